jk_multimode_register: RTL and testbench

- Parametrised WIDTH-bit register built from JK-style next-state cells.
- Supports four modes: per-bit JK, per-bit toggle, synchronous up-count and synchronous down-count.
- Also provides parallel load, clock enable, terminal-count flag and a registered change pulse.
- Drop-in successor for the team's single-bit JK flip-flop in control, sequencing and divider logic.

---
 rtl/jk_multimode_register_pkg.sv | 16 +
 rtl/jk_multimode_register_bit_cell.sv | 19 +
 rtl/jk_multimode_register.sv | 98 +++++++++
 tb/tb_jk_multimode_register.sv | 134 +++++++++++++
 4 files changed

// File: rtl/jk_multimode_register_pkg.sv
// Shared mode encodings and the single-bit JK next-state function for
// jk_multimode_register and its per-bit cell.
package jk_pkg;

  typedef logic [1:0] jk_mode_t;

  localparam jk_mode_t MODE_JK     = 2'b00;
  localparam jk_mode_t MODE_TOGGLE = 2'b01;
  localparam jk_mode_t MODE_UP     = 2'b10;
  localparam jk_mode_t MODE_DN     = 2'b11;

  function automatic logic jk_next(input logic q, input logic j, input logic k);
    return (j & ~q) | (~k & q);
  endfunction

endpackage

// File: rtl/jk_multimode_register_bit_cell.sv
// One-bit next-state cell: classic JK behaviour in JK mode, otherwise a
// T cell driven by the mode-derived toggle from the top level.
import jk_pkg::*;

module jk_bit_cell (
  input  jk_mode_t mode,
  input  logic     q_i,
  input  logic     j_i,
  input  logic     k_i,
  input  logic     toggle_i,
  output logic     d_i
);

  always_comb begin
    if (mode == MODE_JK) d_i = jk_next(q_i, j_i, k_i);
    else                 d_i = q_i ^ toggle_i;
  end

endmodule

// File: rtl/jk_multimode_register.sv
// WIDTH-bit multimode JK register: JK / toggle / up / down count, parallel load.
// Build option: define JK_MULTIMODE_SAT_EN to make the count modes saturate.
import jk_pkg::*;

module jk_multimode_register #(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_n,
  output logic             tc,
  output logic             changed
);

`ifdef JK_MULTIMODE_SAT_EN
  localparam bit SatEn = 1'b1;
`else
  localparam bit SatEn = 1'b0;
`endif

  jk_mode_t         mode_s;
  logic [WIDTH-1:0] q_q, q_d;
  logic             changed_q, changed_d;
  logic [WIDTH-1:0] toggle_vec;
  logic [WIDTH-1:0] cell_d;
  logic             ones_below, zeros_below;
  logic             at_limit;

  assign mode_s = jk_mode_t'(mode);

  // Ripple toggle chain: bit i toggles when all lower bits are ones (up) or zeros (down).
  always_comb begin
    toggle_vec  = '0;
    ones_below  = 1'b1;
    zeros_below = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      case (mode_s)
        MODE_TOGGLE: toggle_vec[i] = j[i];
        MODE_UP:     toggle_vec[i] = ones_below;
        MODE_DN:     toggle_vec[i] = zeros_below;
        default:     toggle_vec[i] = 1'b0;
      endcase
      ones_below  = ones_below & q_q[i];
      zeros_below = zeros_below & ~q_q[i];
    end
    at_limit = ((mode_s == MODE_UP) && (&q_q)) || ((mode_s == MODE_DN) && (q_q == '0));
    if (SatEn && at_limit) toggle_vec = '0;
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_cell
    jk_bit_cell u_cell (
      .mode     (mode_s),
      .q_i      (q_q[g]),
      .j_i      (j[g]),
      .k_i      (k[g]),
      .toggle_i (toggle_vec[g]),
      .d_i      (cell_d[g])
    );
  end

  always_comb begin
    if (load)    q_d = d;
    else if (en) q_d = cell_d;
    else         q_d = q_q;
    changed_d = (q_d != q_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q       <= RST_VAL;
      changed_q <= 1'b0;
    end else begin
      q_q       <= q_d;
      changed_q <= changed_d;
    end
  end

  always_comb begin
    case (mode_s)
      MODE_UP: tc = &q_q;
      MODE_DN: tc = (q_q == '0);
      default: tc = 1'b0;
    endcase
  end

  assign q       = q_q;
  assign q_n     = ~q_q;
  assign changed = changed_q;

endmodule

// File: tb/tb_jk_multimode_register.sv
// Scoreboard bench for jk_multimode_register (WIDTH=8, RST_VAL=8'h5A);
// expectations follow the JK_MULTIMODE_SAT_EN build option when defined.
module tb_jk_multimode_register;

`ifdef JK_MULTIMODE_SAT_EN
  localparam bit SatEn = 1'b1;
`else
  localparam bit SatEn = 1'b0;
`endif

  localparam logic [1:0] M_JK = 2'b00, M_TG = 2'b01, M_UP = 2'b10, M_DN = 2'b11;

  logic       clk, rst, en, load, tc, changed;
  logic [1:0] mode;
  logic [7:0] j, k, d, q, q_n;

  jk_multimode_register #(.WIDTH(8), .RST_VAL(8'h5A)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .j(j), .k(k),
    .load(load), .d(d), .q(q), .q_n(q_n), .tc(tc), .changed(changed)
  );

  typedef struct {
    logic [7:0] q;
    logic       tc;
    logic       chg;
    string      name;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Monitor: each clock edge or reset assertion is a DUT output event.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk or posedge rst);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        n_vec++;
        if (q !== e.q || q_n !== ~e.q || tc !== e.tc || changed !== e.chg) begin
          n_bad++;
          $display("FAIL %s: got q=%h q_n=%h tc=%b changed=%b, want q=%h q_n=%h tc=%b changed=%b",
                   e.name, q, q_n, tc, changed, e.q, ~e.q, e.tc, e.chg);
        end
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "timeout");
  end

  task automatic push(input logic [7:0] eq, input logic etc, input logic echg, input string nm);
    exp_t e;
    e.q = eq; e.tc = etc; e.chg = echg; e.name = nm;
    sb.push_back(e);
  endtask

  task automatic step(input logic ld, input logic ce, input logic [1:0] md,
                      input logic [7:0] jj, input logic [7:0] kk, input logic [7:0] dd,
                      input logic [7:0] eq, input logic etc, input logic echg, input string nm);
    @(negedge clk);
    load = ld; en = ce; mode = md; j = jj; k = kk; d = dd;
    push(eq, etc, echg, nm);
    @(posedge clk);
  endtask

  task automatic async_reset(input logic [1:0] md, input string nm);
    @(negedge clk);
    load = 1'b0; en = 1'b0; mode = md;
    push(8'h5A, 1'b0, 1'b0, nm);
    #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; load = 1'b0; mode = M_JK; j = '0; k = '0; d = '0;

    async_reset(M_JK, "reset_async");
    for (int i = 0; i < 3; i++) step(0, 0, M_JK, 8'h00, 8'h00, 8'h00, 8'h5A, 0, 0, "reset_hold");

    step(1, 0, M_JK, 8'h00, 8'h00, 8'h0F, 8'h0F, 0, 1, "load_0f");
    step(0, 1, M_JK, 8'hF0, 8'h3C, 8'h00, 8'hF3, 0, 1, "jk_mix");

    step(1, 0, M_UP, 8'h00, 8'h00, 8'hFE, 8'hFE, 0, 1, "up_load_fe");
    step(0, 1, M_UP, 8'h00, 8'h00, 8'h00, 8'hFF, 1, 1, "up_ff");
    if (SatEn) step(0, 1, M_UP, 8'h00, 8'h00, 8'h00, 8'hFF, 1, 0, "up_sat");
    else       step(0, 1, M_UP, 8'h00, 8'h00, 8'h00, 8'h00, 0, 1, "up_wrap");

    step(1, 0, M_DN, 8'h00, 8'h00, 8'h01, 8'h01, 0, 1, "dn_load_01");
    step(0, 1, M_DN, 8'h00, 8'h00, 8'h00, 8'h00, 1, 1, "dn_00");
    if (SatEn) begin
      step(0, 1, M_DN, 8'h00, 8'h00, 8'h00, 8'h00, 1, 0, "dn_sat");
      for (int i = 0; i < 2; i++) step(0, 0, M_DN, 8'h00, 8'h00, 8'h00, 8'h00, 1, 0, "dn_en_off");
    end else begin
      step(0, 1, M_DN, 8'h00, 8'h00, 8'h00, 8'hFF, 0, 1, "dn_wrap");
      for (int i = 0; i < 2; i++) step(0, 0, M_DN, 8'h00, 8'h00, 8'h00, 8'hFF, 0, 0, "dn_en_off");
    end

    step(1, 1, M_UP, 8'h00, 8'h00, 8'h33, 8'h33, 0, 1, "prio_load");
    step(1, 1, M_UP, 8'h00, 8'h00, 8'h33, 8'h33, 0, 0, "load_same");

    step(1, 0, M_TG, 8'h00, 8'h00, 8'h00, 8'h00, 0, 1, "tg_load_00");
    step(0, 1, M_TG, 8'hAA, 8'h00, 8'h00, 8'hAA, 0, 1, "tg_aa");
    step(0, 1, M_TG, 8'hAA, 8'h00, 8'h00, 8'h00, 0, 1, "tg_00");
    step(0, 1, M_TG, 8'hAA, 8'h00, 8'h00, 8'hAA, 0, 1, "tg_aa2");
    async_reset(M_TG, "tg_mid_reset");
    step(0, 1, M_UP, 8'h00, 8'h00, 8'h00, 8'h5B, 0, 1, "up_after_rst");
    step(0, 1, M_JK, 8'h01, 8'h01, 8'h00, 8'h5A, 0, 1, "jk_toggle_b0");

    @(negedge clk);
    load = 1'b0; en = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
